// File: rtl/fp_norm_round_pipe.sv
// Normalise-and-round stage for the FP add/sub datapath.
// Stage 1 normalises the raw signed-magnitude sum (carry right-shift or
// leading-zero left-shift). Stage 2 rounds to nearest-even and packs the
// exponent, fraction and one-hot exception flags. Subnormals flush to zero.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake (in_ready combinational on out_ready)
//   sign_in, eff_sub           result sign, effective-subtraction flag
//   new_exponent, sum          pre-normalisation exponent, raw sum {C,H,frac,G,R,S}
//   out_valid/out_ready        output handshake
//   sign_out, updated_exponent, updated_mantissa   packed result
//   exc_in, exc_zero, exc_underflow, exc_overflow  exception flags (one-hot or zero)
module fp_norm_round_pipe #(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned SUM_W = MAN_W + 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic             eff_sub,
  input  logic [EXP_W-1:0] new_exponent,
  input  logic [SUM_W-1:0] sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [EXP_W-1:0] updated_exponent,
  output logic [MAN_W-1:0] updated_mantissa,
  output logic             exc_in,
  output logic             exc_zero,
  output logic             exc_underflow,
  output logic             exc_overflow
);

  localparam int unsigned EXT_W = EXP_W + 1;     // exponent with headroom bit
  localparam int unsigned NRM_W = SUM_W - 1;     // hidden + fraction + GRS
  localparam int unsigned RND_W = MAN_W + 2;     // carry + hidden + fraction
  localparam int unsigned LZ_W  = $clog2(SUM_W);
  localparam logic [EXT_W-1:0] EXP_MAX = EXT_W'({EXP_W{1'b1}});

  // Leading-zero count of the hidden..sticky field; highest set bit wins.
  function automatic logic [LZ_W-1:0] lzc(input logic [NRM_W-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(NRM_W);
    for (int i = 0; i < int'(NRM_W); i++) begin
      if (v[i]) n = LZ_W'(int'(NRM_W) - 1 - i);
    end
    return n;
  endfunction

  // Pipeline registers
  logic             s1_valid_q;
  logic             s1_sign_q;
  logic [EXT_W-1:0] s1_exp_q,  s1_exp_d;
  logic [NRM_W-1:0] s1_man_q,  s1_man_d;
  logic             s1_exc_q,  s1_exc_d;
  logic             s1_zero_q, s1_zero_d;
  logic             s1_unf_q,  s1_unf_d;

  logic             out_valid_q;
  logic             sign_q;
  logic [EXP_W-1:0] exp_q,  exp_d;
  logic [MAN_W-1:0] man_q,  man_d;
  logic             exc_q,  zero_q, unf_q, ovf_q;
  logic             ovf_d;

  logic             s2_adv_c, s1_adv_c;
  logic [EXT_W-1:0] exp_ext;
  logic [LZ_W-1:0]  lz;
  logic             rnd_up;
  logic [RND_W-1:0] rnd_sum;
  logic [EXT_W-1:0] rnd_exp;

  // Flow control: each stage moves when its downstream slot is free or draining.
  assign s2_adv_c = ~out_valid_q | out_ready;
  assign s1_adv_c = ~s1_valid_q | s2_adv_c;
  assign in_ready = s1_adv_c;

  // eff_sub only qualifies how the carry bit arose upstream; no logic needs it here,
  // and the hidden bit of the rounded sum is implied by the normalised result.
  logic unused_ok;
  assign unused_ok = ^{eff_sub, rnd_sum[MAN_W]};

  // Stage 1: normalise, in priority order special > zero > carry > left shift.
  always_comb begin
    s1_exp_d  = '0;
    s1_man_d  = '0;
    s1_exc_d  = 1'b0;
    s1_zero_d = 1'b0;
    s1_unf_d  = 1'b0;
    exp_ext   = {1'b0, new_exponent};
    lz        = lzc(sum[NRM_W-1:0]);
    if (new_exponent == '0 || new_exponent == '1) begin
      s1_exc_d = 1'b1;
    end else if (sum == '0) begin
      s1_zero_d = 1'b1;
    end else if (sum[SUM_W-1]) begin
      // Right shift by one; the dropped bit folds into sticky.
      s1_man_d = {sum[SUM_W-1:2], sum[1] | sum[0]};
      s1_exp_d = exp_ext + EXT_W'(1);
    end else if (EXT_W'(lz) >= exp_ext) begin
      s1_unf_d = 1'b1;
    end else begin
      s1_man_d = sum[NRM_W-1:0] << lz;
      s1_exp_d = exp_ext - EXT_W'(lz);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_man_q   <= '0;
      s1_exc_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_unf_q   <= 1'b0;
    end else if (s1_adv_c) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= sign_in;
        s1_exp_q  <= s1_exp_d;
        s1_man_q  <= s1_man_d;
        s1_exc_q  <= s1_exc_d;
        s1_zero_q <= s1_zero_d;
        s1_unf_q  <= s1_unf_d;
      end
    end
  end

  // Stage 2: round to nearest even, then apply special encodings.
  always_comb begin
    rnd_up  = s1_man_q[2] & (s1_man_q[1] | s1_man_q[0] | s1_man_q[3]);
    rnd_sum = {1'b0, s1_man_q[NRM_W-1:3]} + RND_W'(rnd_up);
    rnd_exp = s1_exp_q + EXT_W'(rnd_sum[RND_W-1]);
    exp_d   = rnd_exp[EXP_W-1:0];
    man_d   = rnd_sum[RND_W-1] ? '0 : rnd_sum[MAN_W-1:0];
    ovf_d   = 1'b0;
    if (s1_exc_q) begin
      exp_d = '1;
      man_d = '0;
    end else if (s1_zero_q || s1_unf_q) begin
      exp_d = '0;
      man_d = '0;
    end else if (rnd_exp >= EXP_MAX) begin
      exp_d = '1;
      man_d = '0;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      man_q       <= '0;
      exc_q       <= 1'b0;
      zero_q      <= 1'b0;
      unf_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (s2_adv_c) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sign_q <= s1_sign_q;
        exp_q  <= exp_d;
        man_q  <= man_d;
        exc_q  <= s1_exc_q;
        zero_q <= s1_zero_q & ~s1_exc_q;
        unf_q  <= s1_unf_q & ~s1_exc_q & ~s1_zero_q;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid        = out_valid_q;
  assign sign_out         = sign_q;
  assign updated_exponent = exp_q;
  assign updated_mantissa = man_q;
  assign exc_in           = exc_q;
  assign exc_zero         = zero_q;
  assign exc_underflow    = unf_q;
  assign exc_overflow     = ovf_q;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Self-checking bench for fp_norm_round_pipe (EXP_W=8, MAN_W=23).
// Directed vectors with hard expected values, backpressure and mid-stream
// reset, then randomised streaming scored against an exact-arithmetic
// round-to-nearest-even reference model.
module tb_fp_norm_round_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic        eff_sub;
  logic [7:0]  new_exponent;
  logic [27:0] sum;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  updated_exponent;
  logic [22:0] updated_mantissa;
  logic        exc_in;
  logic        exc_zero;
  logic        exc_underflow;
  logic        exc_overflow;

  fp_norm_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .sign_in          (sign_in),
    .eff_sub          (eff_sub),
    .new_exponent     (new_exponent),
    .sum              (sum),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .sign_out         (sign_out),
    .updated_exponent (updated_exponent),
    .updated_mantissa (updated_mantissa),
    .exc_in           (exc_in),
    .exc_zero         (exc_zero),
    .exc_underflow    (exc_underflow),
    .exc_overflow     (exc_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [35:0] exp_q[$];      // {sign, exp, frac, flags in/zero/unf/ovf}
  logic [35:0] held;
  logic        stalled = 1'b0;
  logic        in_fire = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] xp);
    n_checks++;
    assert (obs === xp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, xp);
    end
  endtask

  // Exact RNE of the sum treated as an integer, kept to 24 significant bits.
  function automatic logic [35:0] model(input logic sg, input logic [27:0] s, input logic [7:0] e);
    longint v, q, rem, half;
    int     msb, drop, ee;
    if (e == 8'h00 || e == 8'hFF) return {sg, 8'hFF, 23'd0, 4'b1000};
    if (s == 28'd0) return {sg, 8'h00, 23'd0, 4'b0100};
    v = longint'(s);
    msb = 0;
    for (int i = 0; i < 28; i++) if (s[i]) msb = i;
    ee = int'(e) + msb - 26;
    if (ee <= 0) return {sg, 8'h00, 23'd0, 4'b0010};
    drop = msb - 23;
    if (drop <= 0) begin
      q = v << (-drop);
    end else begin
      q    = v >> drop;
      rem  = v - (q << drop);
      half = longint'(1) << (drop - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    end
    if (q == (longint'(1) << 24)) begin
      q  = longint'(1) << 23;
      ee = ee + 1;
    end
    if (ee >= 255) return {sg, 8'hFF, 23'd0, 4'b0001};
    return {sg, 8'(ee), 23'(q - (longint'(1) << 23)), 4'b0000};
  endfunction

  function automatic logic [35:0] obs_word();
    return {sign_out, updated_exponent, updated_mantissa,
            exc_in, exc_zero, exc_underflow, exc_overflow};
  endfunction

  // One clock: sample at negedge, score handshakes, return at posedge+1.
  task automatic step();
    logic [35:0] w;
    @(negedge clk);
    w = obs_word();
    if (stalled) chk("stall_hold", {27'd0, out_valid, w}, {27'd0, 1'b1, held});
    in_fire = in_valid && in_ready;
    if (in_fire) exp_q.push_back(model(sign_in, sum, new_exponent));
    if (out_valid && out_ready) begin
      chk("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("stream_beat", 64'(w), 64'(exp_q.pop_front()));
    end
    stalled = out_valid && !out_ready;
    held    = w;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    int unsigned r, p;
    logic [27:0] mask;
    r = $urandom_range(0, 99);
    if (r < 5) sum = '0;
    else if (r < 12) sum = 28'h7FFFFF8 | 28'($urandom_range(0, 7));
    else if (r < 16) sum = 28'hFFFFFF0 | 28'($urandom_range(0, 15));
    else begin
      p    = $urandom_range(0, 27);
      mask = (28'd1 << p) - 28'd1;
      sum  = (28'd1 << p) | (28'($urandom) & mask);
    end
    eff_sub = sum[27] ? 1'b0 : 1'($urandom);
    r = $urandom_range(0, 99);
    if (r < 8) new_exponent = (r < 4) ? 8'h00 : 8'hFF;
    else if (r < 30) new_exponent = 8'($urandom_range(1, 30));
    else if (r < 45) new_exponent = 8'($urandom_range(240, 254));
    else new_exponent = 8'($urandom_range(1, 254));
    sign_in = 1'($urandom);
  endtask

  task automatic drain();
    int g;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 50) begin
      step();
      g++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic directed(input string tag, input logic [27:0] s, input logic [7:0] e,
                          input logic sub, input logic [7:0] xe, input logic [22:0] xf,
                          input logic [3:0] xfl);
    int   lat;
    logic sg;
    drain();
    sg           = 1'($urandom);
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    sum          = s;
    new_exponent = e;
    eff_sub      = sub;
    sign_in      = sg;
    step();
    chk({tag, "_accept"}, 64'(in_fire), 64'd1);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd2);
    chk({tag, "_exp"},   64'(updated_exponent), 64'(xe));
    chk({tag, "_frac"},  64'(updated_mantissa), 64'(xf));
    chk({tag, "_flags"}, 64'({exc_in, exc_zero, exc_underflow, exc_overflow}), 64'(xfl));
    chk({tag, "_sign"},  64'(sign_out), 64'(sg));
    step();
  endtask

  initial begin
    int   acc, g;
    logic took;

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sign_in = 1'b0;
    eff_sub = 1'b0; new_exponent = '0; sum = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'(obs_word()), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors
    directed("add_carry",  28'h8000000, 8'd127, 1'b0, 8'd128, 23'h000000, 4'b0000);
    directed("cancel",     28'h0000008, 8'd127, 1'b1, 8'd104, 23'h000000, 4'b0000);
    directed("cancel_unf", 28'h0000008, 8'd10,  1'b1, 8'd0,   23'h000000, 4'b0010);
    directed("round_up",   28'h400000C, 8'd127, 1'b0, 8'd127, 23'h000002, 4'b0000);
    directed("tie_even",   28'h4000004, 8'd127, 1'b0, 8'd127, 23'h000000, 4'b0000);
    directed("rnd_carry",  28'h7FFFFFC, 8'd100, 1'b0, 8'd101, 23'h000000, 4'b0000);
    directed("rnd_ovf",    28'h7FFFFFC, 8'd254, 1'b0, 8'd255, 23'h000000, 4'b0001);
    directed("exp_zero",   28'h1234567, 8'd0,   1'b0, 8'hFF,  23'h000000, 4'b1000);
    directed("exp_ones",   28'h4000000, 8'hFF,  1'b0, 8'hFF,  23'h000000, 4'b1000);
    directed("sum_zero",   28'h0000000, 8'd50,  1'b1, 8'd0,   23'h000000, 4'b0100);

    // Backpressure: two beats fill the pipe, third is refused until release
    drain();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_beat(); step();
    rand_beat(); step();
    rand_beat();
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    step();
    step();
    chk("bp_out_valid_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    acc = 0; g = 0;
    while (acc < 2 && g < 20) begin
      step();
      if (in_fire) begin acc++; rand_beat(); end
      g++;
    end
    chk("bp_all_accepted", 64'(acc), 64'd2);
    drain();

    // Mid-stream reset discards everything in flight
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_beat(); step(); end
    chk("mid_rst_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_outputs", 64'(obs_word()), 64'd0);
    exp_q.delete();
    stalled  = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    step(); step();
    chk("post_rst_no_ghost", 64'(out_valid), 64'd0);

    // Randomised streaming with random backpressure
    took = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_beat();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      took = !in_valid || in_fire;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_norm_round_pipe.md
Name: fp_norm_round_pipe

Overview:
- Parametrised, pipelined normalise-and-round stage for the floating-point add/sub datapath.
- Sits after the aligned-mantissa adder and before result packing.
- Takes the raw signed-magnitude sum, its pre-normalisation exponent and the effective-operation flag.
- Produces a normalised, round-to-nearest-even IEEE-style result with exception flags.
- Two-stage pipeline (normalise, round) with valid/ready flow control; no subnormal support (flush to zero).

Parameters:
- EXP_W, 8: exponent width in bits.
- MAN_W, 23: stored fraction width (hidden bit excluded).
- SUM_W, MAN_W+5 (derived, not overridable): sum width. Bit layout:
  - [SUM_W-1] carry
  - [SUM_W-2] hidden
  - [SUM_W-3:3] fraction
  - [2] guard, [1] round, [0] sticky

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept an input beat this cycle
- sign_in  in  1  result sign, passed through unchanged
- eff_sub  in  1  1 = effective subtraction (operand signs differed)
- new_exponent  in  EXP_W  pre-normalisation exponent
- sum  in  SUM_W  raw mantissa sum with GRS bits
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- sign_out  out  1  result sign
- updated_exponent  out  EXP_W  final biased exponent
- updated_mantissa  out  MAN_W  final fraction
- exc_in  out  1  input exponent was 0 or all-ones
- exc_zero  out  1  exact zero result
- exc_underflow  out  1  result flushed to zero
- exc_overflow  out  1  result saturated to exponent all-ones

Behaviour:
- Handshake and timing:
  - Transfer on in_valid&in_ready and on out_valid&out_ready.
  - Latency 2 cycles from input transfer to out_valid when out_ready is held high; throughput 1 beat/cycle.
  - Stage 2 advances when !out_valid | out_ready. Stage 1 advances when !s1_valid | stage 2 advances. in_ready = !s1_valid | stage-2 advance; it may depend combinationally on out_ready.
  - While out_valid & !out_ready, all outputs hold stable. No beat is dropped or duplicated, and order is preserved.
- Reset (async, rst_n low):
  - s1_valid and out_valid go to 0; every data and flag output goes to 0.
  - Reset mid-operation discards in-flight beats.
  - After release, in_ready = 1 on the first cycle.
- Stage 1 (normalise), registered, applied in priority order:
  - new_exponent == 0 or all-ones: mark exc_in.
  - sum == 0: mark zero.
  - carry bit set (only possible when eff_sub = 0): shift right 1, OR the dropped bit into the sticky bit, exponent + 1.
  - Otherwise: lz = leading-zero count of sum[SUM_W-2:0].
    - If lz >= new_exponent: mark underflow.
    - Else: shift left by lz, zero fill, exponent - lz.
- Stage 2 (round), registered:
  - LSB = fraction bit 3, G/R/S = bits 2/1/0.
  - round_up = G & (R | S | LSB), i.e. nearest-even.
  - Add round_up to {hidden, fraction}. On carry out of the hidden bit: fraction = 0, exponent + 1.
  - If the final exponent == all-ones: set exc_overflow, fraction = 0.
- Output encoding:
  - exc_in: exponent all-ones, fraction 0.
  - zero or underflow: exponent 0, fraction 0.
  - Flags are one-hot or all-zero, priority exc_in > zero > underflow > overflow.
- Widths: all exponent arithmetic is done in EXP_W+1 bits so that wrap is never silent. lz occupies clog2(SUM_W) bits.

Test Plan (EXP_W=8, MAN_W=23; sum values are 28-bit hex):
- Add carry: sum=800_0000, exp=127, eff_sub=0 → exp 128, frac 0, no flags, out_valid 2 cycles after accept.
- Cancellation: sum=000_0008, exp=127, eff_sub=1 → left shift 23, exp 104, frac 0. Same sum with exp=10 → exc_underflow=1, exp 0, frac 0.
- Rounding, sum 400_000C → frac 000002 (round up). Tie-to-even, sum 400_0004 → frac 000000 (no round). Both with exp unchanged.
- Round overflow: sum=7FF_FFFC with exp=100 → exp 101, frac 0. Same sum with exp=254 → exp 255, frac 0, exc_overflow=1.
- Specials: exp=0 with any sum → exc_in=1, exp FF, frac 0. sum=0 with exp=50 → exc_zero=1.
- Backpressure: stream 4 beats with out_ready low for 3 cycles → in_ready drops after 2 beats are held, outputs stay stable, all 4 emerge in order. Assert rst_n low mid-stream → out_valid=0 immediately.
